// File: rtl/spis.sv
// spis: SPI mode-0 subordinate with one buffered frame per direction and a two-register bus port.
// All pins are synchronized; miso/miso_oe update three clocks after the pin edge that causes them.
module spis (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe
);
  localparam logic [31:0] IDLE_FILL = 32'hFFFF_FFFF;
  logic [2:0] cs_q, sclk_q;
  logic [1:0] mosi_q, settle_q;
  logic armed_q, armed_d, active_q, active_d, reload_q, reload_d;
  logic [2:0] ctrl_q, ctrl_d, lat_q, lat_d, lw;
  logic [5:0] cnt_q, cnt_d;
  logic [31:0] tx_q, tx_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_q, rx_d, wire_tx, rx_next, status;
  logic tx_full_q, tx_full_d, rx_valid_q, rx_valid_d, ovr_q, ovr_d, udr_q, udr_d, miso_q, miso_d;
  logic sel, desel, rise, fall, load, done, rd_rx, wr_tx, wr_ctl, clr;

  function automatic logic [5:0] nbits(input logic [1:0] w);
    return w == 2'b01 ? 6'd32 : w == 2'b10 ? 6'd16 : 6'd8;
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // Wire order is left-aligned: bit 31 goes out first. c = {msbytefirst, width}.
  function automatic logic [31:0] to_wire(input logic [31:0] v, input logic [2:0] c);
    return c[2] ? v << (6'd32 - nbits(c[1:0])) : bswap(v);
  endfunction

  function automatic logic [31:0] from_wire(input logic [31:0] v, input logic [2:0] c);
    logic [31:0] a;
    a = v << (6'd32 - nbits(c[1:0]));
    return c[2] ? a >> (6'd32 - nbits(c[1:0])) : bswap(a);
  endfunction

  assign sel = armed_q & cs_q[2] & ~cs_q[1];
  assign desel = ~cs_q[2] & cs_q[1];
  assign rise = active_q & sclk_q[1] & ~sclk_q[2];
  assign fall = active_q & ~sclk_q[1] & sclk_q[2];
  assign load = sel | (fall & reload_q);
  assign lw = sel ? ctrl_q : lat_q;
  assign wire_tx = to_wire(tx_full_q ? tx_q : IDLE_FILL, lw);
  assign rx_next = (rx_sh_q << 1) | {31'b0, mosi_q[1]};
  assign done = rise & (cnt_q + 6'd1 == nbits(lat_q[1:0]));
  assign rd_rx = stb & ~we & ~addr;
  assign wr_tx = stb & we & ~addr;
  assign wr_ctl = stb & we & addr;
  assign clr = wr_ctl & data_in[7];
  assign status = {27'b0, udr_q, ovr_q, ~cs_q[1], ~tx_full_q, rx_valid_q};
  assign data_out = (stb & ~we) ? (addr ? status : rx_q) : '0;
  assign ack = stb;
  assign miso = miso_q;
  assign miso_oe = active_q;

  always_comb begin
    // A select only counts once cs_n has been seen high after reset.
    armed_d = armed_q | (settle_q[1] & cs_q[1]);
    active_d = sel | (active_q & ~desel);
    lat_d = sel ? ctrl_q : lat_q;
    ctrl_d = wr_ctl ? data_in[6:4] : ctrl_q;
    tx_d = wr_tx ? data_in : tx_q;
    tx_full_d = wr_tx | (tx_full_q & ~load);
    tx_sh_d = load ? wire_tx : fall ? tx_sh_q << 1 : tx_sh_q;
    miso_d = load ? wire_tx[31] : fall ? tx_sh_q[30] : miso_q;
    rx_sh_d = rise ? rx_next : rx_sh_q;
    cnt_d = (sel | desel | done) ? 6'd0 : rise ? cnt_q + 6'd1 : cnt_q;
    reload_d = ~sel & ~desel & (done | (reload_q & ~fall));
    rx_d = done ? from_wire(rx_next, lat_q) : rx_q;
    rx_valid_d = done | (rx_valid_q & ~rd_rx);
    ovr_d = (done & rx_valid_q & ~rd_rx) | (ovr_q & ~clr);
    udr_d = (load & ~tx_full_q) | (udr_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q <= '1;
      sclk_q <= '0;
      mosi_q <= '1;
      settle_q <= '0;
      armed_q <= 1'b0;
      active_q <= 1'b0;
      reload_q <= 1'b0;
      ctrl_q <= '0;
      lat_q <= '0;
      cnt_q <= '0;
      tx_q <= '0;
      tx_full_q <= 1'b0;
      tx_sh_q <= IDLE_FILL;
      rx_sh_q <= '0;
      rx_q <= '0;
      rx_valid_q <= 1'b0;
      ovr_q <= 1'b0;
      udr_q <= 1'b0;
      miso_q <= 1'b1;
    end else begin
      cs_q <= {cs_q[1:0], cs_n};
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[0], mosi};
      settle_q <= {settle_q[0], 1'b1};
      armed_q <= armed_d;
      active_q <= active_d;
      reload_q <= reload_d;
      ctrl_q <= ctrl_d;
      lat_q <= lat_d;
      cnt_q <= cnt_d;
      tx_q <= tx_d;
      tx_full_q <= tx_full_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx_q <= rx_d;
      rx_valid_q <= rx_valid_d;
      ovr_q <= ovr_d;
      udr_q <= udr_d;
      miso_q <= miso_d;
    end
  end
endmodule

// File: tb/tb_spis.sv
// tb_spis: scoreboard bench for spis; an SPI controller model drives the pins and a
// frame-level reference model predicts bus reads and the words seen on miso.
module tb_spis;
  logic clk = 0, rst = 1, stb = 0, we = 0, addr = 0, cs_n = 1, sclk = 0, mosi = 1;
  logic [31:0] data_in = 0, data_out;
  logic ack, miso, miso_oe;
  int vectors = 0, errors = 0;
  logic [31:0] rd_q[$], spi_q[$];
  logic [31:0] spi_obs;
  event spi_ev;
  logic [31:0] m_tx, m_rx, m_shift;
  bit m_full, m_valid, m_ovr, m_udr, m_msbf, l_msbf;
  logic [1:0] m_w;
  int l_n;

  spis dut (
    .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ack(ack), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (stb && !we) begin
    check("ack", ack, 1);
    if (rd_q.size() == 0) begin
      vectors++; errors++;
      $display("FAIL bus_read: unexpected read, got %h expected none", data_out);
    end else check("bus_read", data_out, rd_q.pop_front());
  end

  initial forever begin
    @(spi_ev);
    if (spi_q.size() == 0) begin
      vectors++; errors++;
      $display("FAIL miso_word: got %h expected none", spi_obs);
    end else check("miso_word", spi_obs, spi_q.pop_front());
  end

  function automatic int width_of(input logic [1:0] w);
    return w == 2'b01 ? 32 : w == 2'b10 ? 16 : 8;
  endfunction

  function automatic logic [31:0] mask(input int n);
    return n == 32 ? 32'hFFFF_FFFF : (32'd1 << n) - 32'd1;
  endfunction

  task automatic m_reset();
    m_tx = 0; m_rx = 0; m_shift = 0; m_full = 0; m_valid = 0;
    m_ovr = 0; m_udr = 0; m_w = 0; m_msbf = 0;
  endtask

  task automatic m_load();
    m_shift = m_full ? m_tx : 32'hFFFF_FFFF;
    if (!m_full) m_udr = 1;
    m_full = 0;
  endtask

  task automatic bus_wr(input logic a, input logic [31:0] d);
    @(posedge clk); #1 stb = 1; we = 1; addr = a; data_in = d;
    @(negedge clk);
    check("ack_wr", ack, 1);
    check("wr_data_out", data_out, 0);
    @(posedge clk); #1 stb = 0; we = 0;
    if (a) begin
      m_w = d[5:4]; m_msbf = d[6];
      if (d[7]) begin m_ovr = 0; m_udr = 0; end
    end else begin
      m_tx = d; m_full = 1;
    end
  endtask

  task automatic bus_rd(input logic a);
    @(posedge clk); #1 stb = 1; we = 0; addr = a;
    @(posedge clk); #1 stb = 0;
  endtask

  task automatic rd_data();
    rd_q.push_back(m_rx);
    m_valid = 0;
    bus_rd(0);
  endtask

  task automatic rd_stat(input bit busy);
    rd_q.push_back({27'b0, m_udr, m_ovr, busy, ~m_full, m_valid});
    bus_rd(1);
  endtask

  task automatic select();
    @(negedge clk) cs_n = 0;
    l_n = width_of(m_w); l_msbf = m_msbf; m_load();
    repeat (2) @(negedge clk);
    check("oe_before_sel", miso_oe, 0);
    @(negedge clk);
    check("oe_after_sel", miso_oe, 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic deselect();
    @(negedge clk) cs_n = 1;
    repeat (2) @(negedge clk);
    check("oe_before_desel", miso_oe, 1);
    @(negedge clk);
    check("oe_after_desel", miso_oe, 0);
    repeat (5) @(negedge clk);
  endtask

  // Clocks nb bits of word w in the latched order; a full frame is scored and reloads tx.
  task automatic xfer(input int nb, input logic [31:0] w);
    logic [31:0] got;
    int idx;
    got = '0;
    if (nb == l_n) spi_q.push_back(m_shift & mask(l_n));
    for (int k = 0; k < nb; k++) begin
      idx = l_msbf ? l_n - 1 - k : (k / 8) * 8 + 7 - k % 8;
      mosi = w[idx];
      repeat (4) @(negedge clk);
      got[idx] = miso;
      sclk = 1;
      repeat (8) @(negedge clk);
      sclk = 0;
      repeat (4) @(negedge clk);
    end
    if (nb == l_n) begin
      if (m_valid) m_ovr = 1;
      m_rx = w & mask(l_n);
      m_valid = 1;
      m_load();
      spi_obs = got;
      -> spi_ev;
    end
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_miso", miso, 1);
    check("rst_oe", miso_oe, 0);
    check("rst_data_out", data_out, 0);
    rst = 0;
    repeat (4) @(negedge clk);
    rd_stat(0);
    rd_data();

    bus_wr(1, 32'h00); bus_wr(0, 32'hA5);
    select(); xfer(8, 32'h3C); deselect();
    rd_stat(0); rd_data(); rd_stat(0);
    bus_wr(1, 32'h80);

    bus_wr(1, 32'h10); bus_wr(0, 32'h1122_3344);
    select(); xfer(32, 32'hDEAD_BEEF); deselect();
    rd_data();
    bus_wr(1, 32'hD0); bus_wr(0, 32'h1122_3344);
    select(); xfer(32, 32'hDEAD_BEEF); deselect();
    rd_data(); rd_stat(0);

    bus_wr(1, 32'h80);
    select(); xfer(8, 32'h5A); xfer(8, 32'hC3); deselect();
    rd_stat(0);
    bus_wr(1, 32'h80); rd_stat(0); rd_data();

    bus_wr(1, 32'h20); bus_wr(0, 32'hBEEF);
    select(); xfer(9, 32'h1234); deselect();
    rd_stat(0);
    bus_wr(0, 32'hCAFE);
    select(); xfer(16, 32'h8001); deselect();
    rd_stat(0); rd_data();

    bus_wr(1, 32'h00); bus_wr(0, 32'h5A);
    select(); xfer(4, 32'hF0);
    @(negedge clk) rst = 1;
    repeat (2) @(negedge clk);
    check("midrst_miso", miso, 1);
    check("midrst_oe", miso_oe, 0);
    check("midrst_data_out", data_out, 0);
    rst = 0;
    m_reset();
    repeat (4) @(negedge clk);
    rd_stat(1);
    for (int k = 0; k < 8; k++) begin
      mosi = 1'($urandom);
      repeat (4) @(negedge clk);
      sclk = 1;
      repeat (8) @(negedge clk);
      sclk = 0;
      repeat (4) @(negedge clk);
    end
    check("ignored_oe", miso_oe, 0);
    rd_stat(1);
    @(negedge clk) cs_n = 1;
    repeat (8) @(negedge clk);
    rd_stat(0);
    bus_wr(0, 32'h69);
    select(); xfer(8, 32'h96); deselect();
    rd_data();

    for (int i = 0; i < 20; i++) begin
      logic [1:0] w;
      logic msbf, clr;
      int frames;
      w = 2'($urandom); msbf = 1'($urandom); clr = 1'($urandom);
      bus_wr(1, {24'h0, clr, msbf, w, 4'h0});
      if ($urandom_range(9) < 7) bus_wr(0, $urandom);
      frames = $urandom_range(1, 2);
      select();
      for (int f = 0; f < frames; f++) xfer(width_of(w), $urandom);
      deselect();
      if ($urandom_range(1)) rd_stat(0);
      if ($urandom_range(1)) rd_data();
    end
    rd_stat(0);

    repeat (4) @(negedge clk);
    check("spi_pending", spi_q.size(), 0);
    check("rd_pending", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
